// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the byte-serial memory bus
//               controller: FSM state encoding, request size encodings and
//               per-size byte counts / last byte indices.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Controller states; width fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // MemLength encodings.
    localparam logic LEN_WORD = 1'b1;
    localparam logic LEN_HALF = 1'b0;

    // Bytes moved per request and the index of the final byte.
    localparam int unsigned BYTES_WORD = 4;
    localparam int unsigned BYTES_HALF = 2;
    localparam logic [1:0]  LAST_WORD  = 2'(BYTES_WORD - 1);
    localparam logic [1:0]  LAST_HALF  = 2'(BYTES_HALF - 1);

    // Index of the final byte for a given request size.
    function automatic logic [1:0] last_idx(input logic len);
        return (len == LEN_WORD) ? LAST_WORD : LAST_HALF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_assembler
// Description : Read path: big-endian shift register that collects bus bytes
//               (first byte ends up most significant). Write path: selects
//               the store byte for a given byte index and request size.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_assembler
    import mem_bus_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_din,
    input  logic [1:0]  i_idx,
    input  logic        i_len,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_wbyte
);

    logic [31:0] r_asm;
    logic [7:0]  w_wbyte;

    // Clearing before each transfer keeps halfword results zero-extended.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_asm <= '0;
        end else if (i_clear) begin
            r_asm <= '0;
        end else if (i_shift) begin
            r_asm <= {r_asm[23:0], i_din};
        end
    end

    // Byte 0 is the most significant byte of the access.
    always_comb begin
        w_wbyte = 8'h00;
        if (i_len == LEN_WORD) begin
            case (i_idx)
                2'd0:    w_wbyte = i_wdata[31:24];
                2'd1:    w_wbyte = i_wdata[23:16];
                2'd2:    w_wbyte = i_wdata[15:8];
                default: w_wbyte = i_wdata[7:0];
            endcase
        end else begin
            w_wbyte = i_idx[0] ? i_wdata[7:0] : i_wdata[15:8];
        end
    end

    assign o_rdata = r_asm;
    assign o_wbyte = w_wbyte;

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Converts one MemRd/MemWr strobe edge (word or halfword) into
//               a sequence of byte accesses on an 8-bit bus, big-endian, and
//               returns a one-cycle MemRdy (with MemErr) to the requester.
//               Optional per-byte bus timeout: define MEM_BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemEnable,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        MemLength,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        MemRdy,
    output logic        MemErr,
    output logic [31:0] BusAddr,
    output logic [7:0]  BusDout,
    input  logic [7:0]  BusDin,
    output logic        BusRd,
    output logic        BusWr,
    input  logic        BusAck
);

    logic        r_prev_rd;
    logic        r_prev_wr;
    logic        w_rise_rd;
    logic        w_rise_wr;
    logic        w_req;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_is_wr;
    logic        r_len;
    logic        r_err;
    logic [1:0]  r_idx;
    logic [1:0]  w_issue_idx;

    logic        w_misaligned;
    logic        w_last;
    logic        w_timeout;

    logic [31:0] w_asm_data;
    logic [7:0]  w_lane_byte;
    logic        w_asm_clear;
    logic        w_asm_shift;

    logic        w_bus_rd_d;
    logic        w_bus_wr_d;
    logic [31:0] w_bus_addr_d;
    logic [7:0]  w_bus_dout_d;
    logic        w_rdy_d;
    logic        w_err_d;
    logic        w_rd_upd;

    // ------------------------------------------------------------------
    // Request detect
    // ------------------------------------------------------------------
    // Strobe history follows the inputs even during reset, so a strobe
    // already high when reset releases never looks like a fresh edge.
    always_ff @(posedge Clk) begin
        r_prev_rd <= MemRd;
        r_prev_wr <= MemWr;
    end

    assign w_rise_rd = MemRd & ~r_prev_rd;
    assign w_rise_wr = MemWr & ~r_prev_wr;
    assign w_req     = MemEnable & (w_rise_rd | w_rise_wr);

    assign w_misaligned = (r_len == LEN_HALF) ? r_addr[0] : (r_addr[1:0] != 2'b00);
    assign w_last       = (r_idx == last_idx(r_len));

    // Byte index presented on the bus by the ISSUE being entered next.
    assign w_issue_idx  = (r_state == ST_CHECK) ? 2'd0 : (r_idx + 2'd1);

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] r_wait_cnt;

    // Counts WAIT cycles of the byte in flight; restarts on every ISSUE.
    always_ff @(posedge Clk) begin
        if (Reset || (r_state == ST_ISSUE)) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !BusAck) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !BusAck &&
                       (r_wait_cnt == TO_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a bus ack beats a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_req) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_misaligned ? ST_DONE : ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (BusAck) begin
                    w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode. Error completions report as DONE is entered; good
    // completions report on leaving DONE, together with the new RdData.
    always_comb begin
        w_bus_rd_d   = 1'b0;
        w_bus_wr_d   = 1'b0;
        w_bus_addr_d = BusAddr;
        w_bus_dout_d = BusDout;
        if (w_state_nxt == ST_ISSUE) begin
            w_bus_rd_d   = ~r_is_wr;
            w_bus_wr_d   = r_is_wr;
            w_bus_addr_d = r_addr + {30'd0, w_issue_idx};
            w_bus_dout_d = w_lane_byte;
        end
        w_err_d     = ((r_state == ST_CHECK) && w_misaligned) || w_timeout;
        w_rdy_d     = w_err_d || ((r_state == ST_DONE) && !r_err);
        w_rd_upd    = (r_state == ST_DONE) && !r_err && !r_is_wr;
        w_asm_clear = (r_state == ST_CHECK);
        w_asm_shift = (r_state == ST_WAIT) && BusAck && !r_is_wr;
    end

    // ------------------------------------------------------------------
    // Request context: latched at acceptance, indexed per byte
    // ------------------------------------------------------------------
    // Write wins when both strobes rise together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_len   <= LEN_HALF;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= Addr;
                        r_wdata <= WrData;
                        r_is_wr <= w_rise_wr;
                        r_len   <= MemLength;
                        r_err   <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_idx <= '0;
                    r_err <= w_misaligned;
                end
                ST_WAIT: begin
                    if (BusAck) begin
                        if (!w_last) begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly / lane select
    // ------------------------------------------------------------------
    mem_byte_assembler u_asm (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_clear (w_asm_clear),
        .i_shift (w_asm_shift),
        .i_din   (BusDin),
        .i_idx   (w_issue_idx),
        .i_len   (r_len),
        .i_wdata (r_wdata),
        .o_rdata (w_asm_data),
        .o_wbyte (w_lane_byte)
    );

    // Registered outputs; RdData only changes on a successful read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RdData  <= '0;
            MemRdy  <= 1'b0;
            MemErr  <= 1'b0;
            BusRd   <= 1'b0;
            BusWr   <= 1'b0;
            BusAddr <= '0;
            BusDout <= '0;
        end else begin
            MemRdy  <= w_rdy_d;
            MemErr  <= w_err_d;
            BusRd   <= w_bus_rd_d;
            BusWr   <= w_bus_wr_d;
            BusAddr <= w_bus_addr_d;
            BusDout <= w_bus_dout_d;
            if (w_rd_upd) begin
                RdData <= w_asm_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Directed self-checking bench for mem_bus_ctrl with a small
//               byte-memory responder (per-byte ack delay, optional no-ack).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b1;
    logic        MemEnable = 1'b0;
    logic        MemRd     = 1'b0;
    logic        MemWr     = 1'b0;
    logic        MemLength = 1'b0;
    logic [31:0] Addr      = '0;
    logic [31:0] WrData    = '0;
    logic [31:0] RdData;
    logic        MemRdy;
    logic        MemErr;
    logic [31:0] BusAddr;
    logic [7:0]  BusDout;
    logic [7:0]  BusDin    = '0;
    logic        BusRd;
    logic        BusWr;
    logic        BusAck    = 1'b0;

    int errors = 0;
    int checks = 0;

    // Responder state
    logic [7:0]  rmem [0:3];
    int          dly  [0:3];
    bit          no_ack = 1'b0;
    bit          pend   = 1'b0;
    int          pcnt   = 0;
    logic [1:0]  paddr  = '0;
    int          n_tot  = 0;
    logic [31:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        log_wr   [0:63];
    int          rdy_cnt = 0;

    mem_bus_ctrl #(.TIMEOUT(16)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemEnable (MemEnable),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .MemLength (MemLength),
        .Addr      (Addr),
        .WrData    (WrData),
        .RdData    (RdData),
        .MemRdy    (MemRdy),
        .MemErr    (MemErr),
        .BusAddr   (BusAddr),
        .BusDout   (BusDout),
        .BusDin    (BusDin),
        .BusRd     (BusRd),
        .BusWr     (BusWr),
        .BusAck    (BusAck)
    );

    always #5 Clk = ~Clk;

    // Byte memory: logs each strobe, acks in the following cycle plus dly.
    always @(negedge Clk) begin
        BusAck = 1'b0;
        if (pend) begin
            if (pcnt == 0) begin
                BusAck = 1'b1;
                BusDin = rmem[paddr];
                pend   = 1'b0;
            end else begin
                pcnt = pcnt - 1;
            end
        end
        if (BusRd || BusWr) begin
            if (n_tot < 64) begin
                log_addr[n_tot] = BusAddr;
                log_data[n_tot] = BusDout;
                log_wr[n_tot]   = BusWr;
            end
            n_tot = n_tot + 1;
            pend  = !no_ack;
            pcnt  = dly[BusAddr[1:0]];
            paddr = BusAddr[1:0];
        end
    end

    // Completion pulse counter.
    always @(negedge Clk) begin
        if (MemRdy) rdy_cnt = rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = cycles from request cycle T to MemRdy (-1 if none).
    task automatic run_req(input logic wr, input logic len, input logic [31:0] a,
                           input logic [31:0] wd, input int budget,
                           output int lat, output logic err_at);
        MemEnable = 1'b1;
        MemLength = len;
        Addr      = a;
        WrData    = wd;
        if (wr) MemWr = 1'b1;
        else    MemRd = 1'b1;
        lat    = -1;
        err_at = 1'b0;
        tick();
        MemRd = 1'b0;
        MemWr = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            if (MemRdy) begin
                lat    = n;
                err_at = MemErr;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   r0;
        int   lat;
        logic eat;

        for (int i = 0; i < 4; i++) begin
            rmem[i] = 8'h00;
            dly[i]  = 0;
        end

        // Reset values, with a strobe held high across reset release
        Reset = 1'b1; MemEnable = 1'b1; MemRd = 1'b1;
        repeat (3) tick();
        chk("rst_RdData",  RdData,  32'h0);
        chk("rst_MemRdy",  {31'd0, MemRdy}, 32'h0);
        chk("rst_MemErr",  {31'd0, MemErr}, 32'h0);
        chk("rst_BusRd",   {31'd0, BusRd},  32'h0);
        chk("rst_BusWr",   {31'd0, BusWr},  32'h0);
        chk("rst_BusAddr", BusAddr, 32'h0);
        chk("rst_BusDout", {24'd0, BusDout}, 32'h0);
        Reset = 1'b0;
        base = n_tot; r0 = rdy_cnt;
        repeat (4) tick();
        chk("held_strobe_bus", n_tot - base, 0);
        chk("held_strobe_rdy", rdy_cnt - r0, 0);
        MemRd = 1'b0;
        repeat (2) tick();

        // Word read at 0x100, zero-wait
        rmem[0] = 8'h12; rmem[1] = 8'h34; rmem[2] = 8'h56; rmem[3] = 8'h78;
        base = n_tot;
        run_req(1'b0, 1'b1, 32'h100, 32'h0, 20, lat, eat);
        chk("wr_rd_latency", lat, 11);
        chk("wr_rd_err", {31'd0, eat}, 32'h0);
        chk("wr_rd_data", RdData, 32'h12345678);
        chk("wr_rd_nbytes", n_tot - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_rd_addr", log_addr[base + i], 32'h100 + i);
            chk("wr_rd_isread", {31'd0, log_wr[base + i]}, 32'h0);
        end
        tick();
        chk("rdy_one_cycle", {31'd0, MemRdy}, 32'h0);
        tick();

        // Halfword write 0xBEEF at 0x202 (upper WrData bits ignored)
        base = n_tot;
        run_req(1'b1, 1'b0, 32'h202, 32'h1234BEEF, 20, lat, eat);
        chk("hw_wr_latency", lat, 7);
        chk("hw_wr_err", {31'd0, eat}, 32'h0);
        chk("hw_wr_nbytes", n_tot - base, 2);
        chk("hw_wr_addr0", log_addr[base], 32'h202);
        chk("hw_wr_data0", {24'd0, log_data[base]}, 32'hBE);
        chk("hw_wr_iswr0", {31'd0, log_wr[base]}, 32'h1);
        chk("hw_wr_addr1", log_addr[base + 1], 32'h203);
        chk("hw_wr_data1", {24'd0, log_data[base + 1]}, 32'hEF);
        chk("hw_wr_rddata_kept", RdData, 32'h12345678);
        repeat (2) tick();

        // Misaligned word read at 0x101; a MemRd edge in DONE is dropped
        base = n_tot; r0 = rdy_cnt;
        MemEnable = 1'b1; MemLength = 1'b1; Addr = 32'h101; MemRd = 1'b1;
        tick();
        MemRd = 1'b0;
        tick();
        chk("mis_rdy_T2", {31'd0, MemRdy}, 32'h1);
        chk("mis_err_T2", {31'd0, MemErr}, 32'h1);
        MemRd = 1'b1;
        repeat (6) tick();
        chk("mis_no_bus", n_tot - base, 0);
        chk("mis_one_rdy", rdy_cnt - r0, 1);
        chk("mis_rddata_kept", RdData, 32'h12345678);
        MemRd = 1'b0;
        repeat (2) tick();

        // Word read with 3 extra wait cycles on byte 2
        rmem[0] = 8'hA1; rmem[1] = 8'hB2; rmem[2] = 8'hC3; rmem[3] = 8'hD4;
        dly[2] = 3;
        run_req(1'b0, 1'b1, 32'h300, 32'h0, 30, lat, eat);
        chk("dly_latency", lat, 14);
        chk("dly_err", {31'd0, eat}, 32'h0);
        chk("dly_data", RdData, 32'hA1B2C3D4);
        dly[2] = 0;
        repeat (2) tick();

        // Reset while waiting on byte 1
        dly[1] = 5;
        base = n_tot;
        MemEnable = 1'b1; MemLength = 1'b1; Addr = 32'h400; MemRd = 1'b1;
        tick();
        MemRd = 1'b0;
        r0 = rdy_cnt;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (n_tot >= base + 2) break;
        end
        chk("rstw_reached_byte1", n_tot - base, 2);
        Reset = 1'b1;
        tick();
        chk("rstw_MemRdy", {31'd0, MemRdy}, 32'h0);
        chk("rstw_BusRd",  {31'd0, BusRd},  32'h0);
        chk("rstw_BusWr",  {31'd0, BusWr},  32'h0);
        chk("rstw_RdData", RdData, 32'h0);
        chk("rstw_BusAddr", BusAddr, 32'h0);
        Reset = 1'b0;
        repeat (10) tick();
        chk("rstw_no_rdy", rdy_cnt - r0, 0);
        dly[1] = 0;

        // Halfword read after reset, zero-extended
        rmem[0] = 8'h5A; rmem[1] = 8'hA5;
        run_req(1'b0, 1'b0, 32'h500, 32'h0, 20, lat, eat);
        chk("hw_rd_latency", lat, 7);
        chk("hw_rd_err", {31'd0, eat}, 32'h0);
        chk("hw_rd_data", RdData, 32'h00005AA5);
        repeat (2) tick();

        // Memory never acknowledges
        no_ack = 1'b1;
        base = n_tot;
`ifdef MEM_BUS_TIMEOUT_EN
        run_req(1'b0, 1'b1, 32'h600, 32'h0, 40, lat, eat);
        chk("to_latency", lat, 19);
        chk("to_err", {31'd0, eat}, 32'h1);
        chk("to_rddata_kept", RdData, 32'h00005AA5);
`else
        run_req(1'b0, 1'b1, 32'h600, 32'h0, 40, lat, eat);
        chk("stall_no_rdy", lat, -1);
        chk("stall_one_byte", n_tot - base, 1);
        chk("stall_addr_held", BusAddr, 32'h600);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
`endif
        no_ack = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
